mem_read_arbiter: RTL
=====================

Name: mem_read_arbiter

Overview:
- Shares the SRAM read port of the memory farm among the six read clients (pool, cnn_wgt, cnn_pic, fcc_bias, fcc_wgt, fcc_pic).
- Chooses one requester, issues its burst of row reads, counts the returned data, and routes valid/last strobes back to the owner.
- Sits between the client read interfaces and the mem_ctrl/mem_sram read path.
- Uses round-robin arbitration, with an optional fixed-priority override taken from client_priority.

Parameters:
- NUM_CLIENTS, 6, number of read requesters. Index 0 = pool, 1 = cnn_wgt, 2 = cnn_pic, 3 = fcc_bias, 4 = fcc_wgt, 5 = fcc_pic.
- ADDR_W, 19, SRAM row address width.
- LEN_W, 8, burst length width, in 256-bit rows.
- MAX_OUT, 4, maximum number of reads issued but not yet returned.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- client_req  in  NUM_CLIENTS  level request, one bit per client.
- client_addr  in  NUM_CLIENTS*ADDR_W  start row per client, client i at [i*ADDR_W +: ADDR_W].
- client_len  in  NUM_CLIENTS*LEN_W  burst length in rows per client.
- client_priority  in  5  bit 4 = fixed-priority enable; [2:0] = favoured client index.
- client_gnt  out  NUM_CLIENTS  one-hot, one-cycle accept pulse.
- client_rvalid  out  NUM_CLIENTS  one-hot, read data valid for the owner.
- client_last  out  NUM_CLIENTS  one-hot, asserted together with the final rvalid.
- sram_read  out  1  read strobe toward the SRAM path.
- sram_addr  out  ADDR_W  row address for the current sram_read.
- sram_rvalid  in  1  read data returned by the SRAM path, in order.
- busy  out  1  high whenever state is not IDLE.
- err  out  1  sticky flag; set by sram_rvalid while nothing is outstanding.

Behaviour:
- Reset values: every output is 0; state = IDLE; rr_ptr = 0; all counters = 0.
- IDLE:
  - Each cycle, compute a winner w from client_req.
  - If w exists: register client_gnt[w] = 1 for the next cycle; latch addr_w, len_w and owner = w.
  - If len_w != 0, go to ISSUE. If len_w == 0, stay in IDLE: the gnt pulse is still given, with no reads and no rvalid/last.
  - In both cases rr_ptr becomes (w+1) mod NUM_CLIENTS.
- Arbitration:
  - If client_priority[4] = 1, client_priority[2:0] < NUM_CLIENTS and that client is requesting, it wins.
  - Otherwise, the first requesting client scanning upward from rr_ptr, with wrap, wins.
  - A favoured index >= NUM_CLIENTS means pure round-robin.
- ISSUE:
  - First cycle in ISSUE coincides with the gnt pulse. sram_read = 1 and sram_addr = addr_w on that cycle, giving 1-cycle latency from the sampled request.
  - Each later cycle issues the next row, address + 1, wrapping modulo 2^ADDR_W.
  - A read is issued only if outstanding < MAX_OUT; otherwise sram_read = 0 (stall).
  - After len_w reads have been issued, go to DRAIN.
- DRAIN: wait until the returned count equals len_w, then go to IDLE. The next arbitration happens in the IDLE cycle, so there is one idle cycle between bursts.
- Return path:
  - Each sram_rvalid while a burst is active drives client_rvalid[owner] = 1 in the same cycle (combinational).
  - client_last[owner] = 1 on the len_w-th return.
  - A return may arrive in the same cycle as an issue. In that cycle the outstanding count stays unchanged (+1 and -1).
- Counters:
  - issued and returned are LEN_W bits wide.
  - outstanding is clog2(MAX_OUT+1) bits wide.
  - No overflow is possible because len_w < 2^LEN_W.
- A requester must hold client_req until it sees gnt; its addr and len are sampled only in the winning cycle.
- client_req is ignored outside IDLE; client_gnt is never issued outside IDLE.
- sram_rvalid with outstanding = 0 is ignored for routing and sets err, which stays set until rst.
- rst asserted mid-burst aborts immediately. All outputs drop to 0 asynchronously. Returns in flight after reset release set err.

Decomposition:
- Package mem_arb_pkg holds:
  - the NUM_CLIENTS, ADDR_W and LEN_W defaults;
  - a client index enum (CL_POOL .. CL_FCC_PIC);
  - a state enum {IDLE, ISSUE, DRAIN}.
- One sub-module, mem_rr_picker, is natural. It is combinational: inputs req vector, rr_ptr, fixed_en and fixed_idx; outputs found and winner index.

Test Plan:
- Single client: cnn_pic req, addr = 0x100, len = 3 → gnt[2] for 1 cycle. sram_addr = 0x100, 0x101, 0x102 on consecutive cycles. With 2-cycle SRAM return: rvalid[2] three times, last[2] on the third; busy then falls.
- Round-robin: all six requesting, len = 1, client_priority = 0 → grant order 0, 1, 2, 3, 4, 5, 0.
- Fixed priority: client_priority = 5'b10100, clients 1 and 4 requesting continuously → client 4 is granted every time.
- Back-pressure: SRAM return delay 8 cycles, len = 10, MAX_OUT = 4 → never more than 4 outstanding; all 10 returned; last asserted exactly once.
- Edge cases:
  - len = 0 → gnt pulse with no sram_read.
  - addr = 0x7FFFF, len = 2 → addresses 0x7FFFF, then 0x00000.
- Errors and reset:
  - Spurious sram_rvalid in IDLE → err = 1, stays set.
  - rst asserted mid-burst → all outputs 0 immediately, rr_ptr = 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the SRAM read-port arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_NUM_CLIENTS = 6;
    localparam int unsigned DEF_ADDR_W      = 19;
    localparam int unsigned DEF_LEN_W       = 8;
    localparam int unsigned DEF_MAX_OUT     = 4;
    localparam int unsigned PRIO_W          = 5;
    localparam int unsigned PRIO_IDX_W      = 3;
    localparam int unsigned PRIO_EN_BIT     = 4;

    typedef enum logic [2:0] {
        CL_POOL     = 3'd0,
        CL_CNN_WGT  = 3'd1,
        CL_CNN_PIC  = 3'd2,
        CL_FCC_BIAS = 3'd3,
        CL_FCC_WGT  = 3'd4,
        CL_FCC_PIC  = 3'd5
    } client_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Round-robin pointer successor with wrap at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_rr_picker.sv
// Combinational requester selection: round-robin from a pointer, with an
// optional favoured client that wins whenever it is requesting.
module mem_rr_picker
    import mem_arb_pkg::*;
#(
    parameter int unsigned N     = DEF_NUM_CLIENTS,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1,
    parameter int unsigned FIX_W = PRIO_IDX_W
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_rr_ptr,
    input  logic             i_fixed_en,
    input  logic [FIX_W-1:0] i_fixed_idx,
    output logic             o_found,
    output logic [IDX_W-1:0] o_winner
);

    int w_idx;

    always_comb begin
        o_found  = 1'b0;
        o_winner = '0;
        w_idx    = 0;
        // Scan offsets high-to-low so the nearest requester after the pointer is written last.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            w_idx = int'(i_rr_ptr) + i;
            if (w_idx >= int'(N)) begin
                w_idx = w_idx - int'(N);
            end
            if (i_req[IDX_W'(w_idx)]) begin
                o_found  = 1'b1;
                o_winner = IDX_W'(w_idx);
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (i_fixed_en && (i_fixed_idx == FIX_W'(i)) && i_req[IDX_W'(i)]) begin
                o_found  = 1'b1;
                o_winner = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares the SRAM read port among the read clients: picks an owner, issues its
// row burst with a cap on reads in flight, and routes returns back to it.
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = DEF_NUM_CLIENTS,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned LEN_W       = DEF_LEN_W,
    parameter int unsigned MAX_OUT     = DEF_MAX_OUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLIENTS-1:0]        client_req,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] client_addr,
    input  logic [NUM_CLIENTS*LEN_W-1:0]  client_len,
    input  logic [PRIO_W-1:0]             client_priority,
    output logic [NUM_CLIENTS-1:0]        client_gnt,
    output logic [NUM_CLIENTS-1:0]        client_rvalid,
    output logic [NUM_CLIENTS-1:0]        client_last,
    output logic                          sram_read,
    output logic [ADDR_W-1:0]             sram_addr,
    input  logic                          sram_rvalid,
    output logic                          busy,
    output logic                          err
);

    localparam int unsigned IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

    state_e                 r_state;
    state_e                 w_state_next;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [IDX_W-1:0]       r_owner;
    logic [IDX_W-1:0]       w_winner;
    logic                   w_found;
    logic [ADDR_W-1:0]      r_addr;
    logic [ADDR_W-1:0]      w_req_addr;
    logic [LEN_W-1:0]       r_len;
    logic [LEN_W-1:0]       w_req_len;
    logic [LEN_W-1:0]       r_issued;
    logic [LEN_W-1:0]       r_returned;
    logic [OUT_W-1:0]       r_outstanding;
    logic [NUM_CLIENTS-1:0] r_gnt;
    logic                   r_err;
    logic                   w_arb;
    logic                   w_issue;
    logic                   w_ret;
    logic                   w_last_issue;
    logic                   w_last_ret;
    logic                   w_unused_prio;

    assign w_unused_prio = client_priority[PRIO_IDX_W];

    mem_rr_picker #(
        .N     (NUM_CLIENTS),
        .IDX_W (IDX_W),
        .FIX_W (PRIO_IDX_W)
    ) u_picker (
        .i_req       (client_req),
        .i_rr_ptr    (r_rr_ptr),
        .i_fixed_en  (client_priority[PRIO_EN_BIT]),
        .i_fixed_idx (client_priority[PRIO_IDX_W-1:0]),
        .o_found     (w_found),
        .o_winner    (w_winner)
    );

    // Winner's start row and burst length.
    always_comb begin
        w_req_addr = '0;
        w_req_len  = '0;
        for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
            if (w_winner == IDX_W'(i)) begin
                w_req_addr = client_addr[i*ADDR_W +: ADDR_W];
                w_req_len  = client_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // A return only counts while something is in flight; otherwise it is an error.
    assign w_arb        = (r_state == IDLE) && w_found;
    assign w_issue      = (r_state == ISSUE) && (r_outstanding < OUT_W'(MAX_OUT));
    assign w_ret        = sram_rvalid && (r_outstanding != '0);
    assign w_last_issue = w_issue && ((r_issued + LEN_W'(1)) == r_len);
    assign w_last_ret   = w_ret && ((r_returned + LEN_W'(1)) == r_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_arb && (w_req_len != '0)) w_state_next = ISSUE;
            ISSUE:   if (w_last_issue)               w_state_next = DRAIN;
            DRAIN:   if (w_last_ret)                 w_state_next = IDLE;
            default:                                 w_state_next = IDLE;
        endcase
    end

    always_comb begin
        sram_read     = w_issue;
        sram_addr     = w_issue ? r_addr : '0;
        busy          = (r_state != IDLE);
        client_rvalid = '0;
        client_last   = '0;
        if (w_ret) begin
            client_rvalid[r_owner] = 1'b1;
        end
        if (w_last_ret) begin
            client_last[r_owner] = 1'b1;
        end
    end

    assign client_gnt = r_gnt;
    assign err        = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt         <= '0;
            r_rr_ptr      <= '0;
            r_owner       <= '0;
            r_addr        <= '0;
            r_len         <= '0;
            r_issued      <= '0;
            r_returned    <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            r_gnt <= '0;
            if (w_arb) begin
                r_gnt      <= NUM_CLIENTS'(1) << w_winner;
                r_owner    <= w_winner;
                r_addr     <= w_req_addr;
                r_len      <= w_req_len;
                r_issued   <= '0;
                r_returned <= '0;
                r_rr_ptr   <= IDX_W'(rr_next(32'(w_winner), NUM_CLIENTS));
            end
            if (w_issue) begin
                r_issued <= r_issued + LEN_W'(1);
                r_addr   <= r_addr + ADDR_W'(1);
            end
            if (w_ret) begin
                r_returned <= r_returned + LEN_W'(1);
            end
            case ({w_issue, w_ret})
                2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (sram_rvalid && (r_outstanding == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
